// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the two-port SRAM arbiter: FSM states, owner ids, strobe counter width.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of fetch port, load/store port and SRAM pins; master = CPU+memory side, slave = arbiter.
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              sram_cs;
  logic              sram_oe;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic [DATA_W-1:0] sram_dout;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, sram_dout,
    input  if_ack, if_rdata, d_ack, d_rdata,
    input  sram_cs, sram_oe, sram_we, sram_addr, sram_din
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, sram_dout,
    output if_ack, if_rdata, d_ack, d_rdata,
    output sram_cs, sram_oe, sram_we, sram_addr, sram_din
  );

endinterface

// File: rtl/sram_arbiter_rr_arb2.sv
// Combinational two-requester round-robin picker; on a tie the port that did not win last time wins.
// Zero latency; grant is one-hot or zero, indexed by owner encoding.
module sram_arbiter_rr_arb2
  import sram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req[OWN_DATA] && (!req[OWN_FETCH] || last == OWN_FETCH)) begin
      grant[OWN_DATA] = 1'b1;
    end else if (req[OWN_FETCH]) begin
      grant[OWN_FETCH] = 1'b1;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between fetch and load/store ports: grant, setup cycle, STROBE_CYC strobe, ack.
// Ack arrives STROBE_CYC+2 cycles after the grant edge; requesters hold req until their ack.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STROBE_CYC = 2
) (
  input logic           clk,
  input logic           reset,
  sram_arbiter_if.slave bus
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              owner_q;
  logic              we_l_q;
  logic              last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              cs_q, oe_q, we_q, if_ack_q, d_ack_q;
  logic              cs_d, oe_d, we_d, if_ack_d, d_ack_d;
  logic [1:0]        req;
  logic [1:0]        gnt;

  // Bit position of each request equals its owner encoding.
  assign req = {bus.d_req, bus.if_req};

  sram_arbiter_rr_arb2 u_rr (
    .req   (req),
    .last  (last_q),
    .grant (gnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (|gnt) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_STROBE;
      ST_STROBE: if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the pins come straight off flops.
  always_comb begin
    cs_d     = (state_d == ST_SETUP) || (state_d == ST_STROBE);
    oe_d     = (state_d == ST_STROBE) && !we_l_q;
    we_d     = (state_d == ST_STROBE) && we_l_q;
    if_ack_d = (state_d == ST_DONE) && (owner_q == OWN_FETCH);
    d_ack_d  = (state_d == ST_DONE) && (owner_q == OWN_DATA);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q       <= 1'b0;
      oe_q       <= 1'b0;
      we_q       <= 1'b0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      owner_q    <= OWN_FETCH;
      last_q     <= OWN_FETCH;
      we_l_q     <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      cs_q     <= cs_d;
      oe_q     <= oe_d;
      we_q     <= we_d;
      if_ack_q <= if_ack_d;
      d_ack_q  <= d_ack_d;
      case (state_q)
        ST_IDLE: begin
          if (|gnt) begin
            owner_q <= gnt[OWN_DATA];
            last_q  <= gnt[OWN_DATA];
            if (gnt[OWN_DATA]) begin
              addr_q <= bus.d_addr;
              we_l_q <= bus.d_we;
              din_q  <= bus.d_wdata;
            end else begin
              addr_q <= bus.if_addr;
              we_l_q <= 1'b0;
              din_q  <= '0;
            end
          end
        end
        ST_SETUP: cnt_q <= CNT_W'(STROBE_CYC - 1);
        ST_STROBE: begin
          if (cnt_q == '0) begin
            if (!we_l_q) begin
              if (owner_q == OWN_DATA) d_rdata_q <= bus.sram_dout;
              else                     if_rdata_q <= bus.sram_dout;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sram_cs   = cs_q;
  assign bus.sram_oe   = oe_q;
  assign bus.sram_we   = we_q;
  assign bus.sram_addr = addr_q;
  assign bus.sram_din  = din_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: default build plus a STROBE_CYC=1 build, each with a behavioural SRAM.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int S0 = 2;
  localparam int S1 = 1;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fail;

  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus  ();
  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .STROBE_CYC(S0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .STROBE_CYC(S1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
  endfunction

  // Behavioural single-port SRAMs: write while cs&we, read data driven while cs&oe.
  logic [31:0] sram0 [logic [31:0]];
  logic [31:0] sram1 [logic [31:0]];

  always @(negedge clk) begin
    if (bus.sram_cs && bus.sram_we) sram0[bus.sram_addr] = bus.sram_din;
    if (bus.sram_cs && bus.sram_oe)
      bus.sram_dout = sram0.exists(bus.sram_addr) ? sram0[bus.sram_addr] : init_word(bus.sram_addr);
    else
      bus.sram_dout = 32'hdead_beef;
  end

  always @(negedge clk) begin
    if (bus1.sram_cs && bus1.sram_we) sram1[bus1.sram_addr] = bus1.sram_din;
    if (bus1.sram_cs && bus1.sram_oe)
      bus1.sram_dout = sram1.exists(bus1.sram_addr) ? sram1[bus1.sram_addr] : init_word(bus1.sram_addr);
    else
      bus1.sram_dout = 32'hdead_beef;
  end

  // Reference model: memory contents, expected rdata registers, round-robin history, ack log.
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] exp_if_rd;
  logic [31:0] exp_d_rd;
  logic        model_last;
  logic        ack_port_q [$];
  int          ack_cyc_q  [$];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  // One request on dut; exact=1 means the port is known to be granted on the first edge.
  task automatic txn(input logic port, input logic wr, input logic [31:0] a,
                     input logic [31:0] wd, input bit exact);
    bit          got;
    int          k;
    logic [31:0] exp_din;
    logic [3:0]  exp_v;
    logic [3:0]  got_v;
    logic        own_ack;
    logic        oth_ack;
    got = 0;
    k = 0;
    exp_din = (port == OWN_DATA) ? wd : 32'h0;
    if (port == OWN_DATA) begin
      bus.d_req = 1'b1; bus.d_we = wr; bus.d_addr = a; bus.d_wdata = wd;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = a;
    end
    while (!got && k < 2*S0+8) begin
      @(negedge clk);
      k++;
      own_ack = (port == OWN_DATA) ? bus.d_ack : bus.if_ack;
      oth_ack = (port == OWN_DATA) ? bus.if_ack : bus.d_ack;
      if (exact && k <= 2+S0) begin
        exp_v = {(k <= 1+S0), (k >= 2 && k <= 1+S0 && !wr), (k >= 2 && k <= 1+S0 && wr), (k == 2+S0)};
        got_v = {bus.sram_cs, bus.sram_oe, bus.sram_we, own_ack};
        n_checks++;
        if (got_v !== exp_v) begin
          n_fail++;
          $display("FAIL strobe_profile port=%0d k=%0d cs/oe/we/ack got %b expected %b", port, k, got_v, exp_v);
        end
        if (k <= 1+S0) begin
          n_checks++;
          if (bus.sram_addr !== a || bus.sram_din !== exp_din) begin
            n_fail++;
            $display("FAIL latched_bus port=%0d k=%0d addr/din got %h/%h expected %h/%h",
                     port, k, bus.sram_addr, bus.sram_din, a, exp_din);
          end
        end
        if (port == OWN_DATA) begin
          bus.d_addr = $urandom; bus.d_wdata = $urandom;
        end else begin
          bus.if_addr = $urandom;
        end
      end
      if (own_ack) begin
        got = 1;
        ack_port_q.push_back(port);
        ack_cyc_q.push_back(cyc);
        model_last = port;
        if (!exact) begin
          n_checks++;
          if (k > 2*S0+5) begin
            n_fail++;
            $display("FAIL starvation port=%0d ack after %0d cycles, limit %0d", port, k, 2*S0+5);
          end
        end
        n_checks++;
        if (oth_ack !== 1'b0) begin
          n_fail++;
          $display("FAIL other_ack port=%0d other ack got %b expected 0", port, oth_ack);
        end
        if (wr) ref_mem[a] = wd;
        else if (port == OWN_DATA) exp_d_rd = ref_rd(a);
        else exp_if_rd = ref_rd(a);
        n_checks++;
        if (bus.if_rdata !== exp_if_rd || bus.d_rdata !== exp_d_rd) begin
          n_fail++;
          $display("FAIL rdata port=%0d addr=%h if/d got %h/%h expected %h/%h",
                   port, a, bus.if_rdata, bus.d_rdata, exp_if_rd, exp_d_rd);
        end
        if (port == OWN_DATA) bus.d_req = 1'b0;
        else bus.if_req = 1'b0;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout port=%0d addr=%h no ack within %0d cycles", port, a, k);
      if (port == OWN_DATA) bus.d_req = 1'b0;
      else bus.if_req = 1'b0;
    end else begin
      @(negedge clk);
      own_ack = (port == OWN_DATA) ? bus.d_ack : bus.if_ack;
      n_checks++;
      if (own_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL ack_width port=%0d ack still %b one cycle later, expected 0", port, own_ack);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h0040_0050;
    bus.d_req = 1'b1;  bus.d_we = 1'b0; bus.d_addr = 32'h1000_0024; bus.d_wdata = 32'h0;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if ({bus.sram_cs, bus.sram_oe, bus.sram_we, bus.if_ack, bus.d_ack,
           bus.sram_addr, bus.sram_din, bus.if_rdata, bus.d_rdata} !== '0) begin
        n_fail++;
        $display("FAIL reset_state cs/oe/we/acks=%b%b%b%b%b addr=%h din=%h rd=%h/%h expected all 0",
                 bus.sram_cs, bus.sram_oe, bus.sram_we, bus.if_ack, bus.d_ack,
                 bus.sram_addr, bus.sram_din, bus.if_rdata, bus.d_rdata);
      end
    end
    exp_if_rd = '0;
    exp_d_rd = '0;
    model_last = OWN_FETCH;
    ack_port_q.delete();
    ack_cyc_q.delete();
    reset = 1'b0;
    fork
      txn(OWN_DATA, 1'b0, 32'h1000_0024, 32'h0, 1'b1);
      txn(OWN_FETCH, 1'b0, 32'h0040_0050, 32'h0, 1'b0);
    join
    n_checks++;
    if (ack_port_q.size() != 2 || ack_port_q[0] !== OWN_DATA) begin
      n_fail++;
      $display("FAIL first_grant acks=%0d first owner got %b expected %b",
               ack_port_q.size(), (ack_port_q.size() > 0) ? ack_port_q[0] : 1'bx, OWN_DATA);
    end
  endtask

  task automatic test_store_load();
    txn(OWN_DATA, 1'b1, 32'h1000_0024, 32'h0000_0007, 1'b1);
    txn(OWN_DATA, 1'b1, 32'h1000_0024, 32'h0000_0009, 1'b1);
    txn(OWN_DATA, 1'b0, 32'h1000_0024, 32'h0, 1'b1);
    n_checks++;
    if (bus.d_rdata !== 32'h0000_0009) begin
      n_fail++;
      $display("FAIL store_then_load d_rdata got %h expected 00000009", bus.d_rdata);
    end
  endtask

  task automatic test_single_fetch();
    txn(OWN_FETCH, 1'b0, 32'h0040_0050, 32'h0, 1'b1);
  endtask

  task automatic test_alternate();
    logic first;
    logic exp_p;
    first = !model_last;
    ack_port_q.delete();
    ack_cyc_q.delete();
    fork
      repeat (4) txn(OWN_DATA, 1'b0, 32'h1000_0024, 32'h0, 1'b0);
      repeat (4) txn(OWN_FETCH, 1'b0, 32'h0040_002c, 32'h0, 1'b0);
    join
    n_checks++;
    if (ack_port_q.size() != 8) begin
      n_fail++;
      $display("FAIL alt_count acks got %0d expected 8", ack_port_q.size());
    end
    for (int i = 0; i < ack_port_q.size(); i++) begin
      exp_p = (i % 2 == 0) ? first : !first;
      n_checks++;
      if (ack_port_q[i] !== exp_p) begin
        n_fail++;
        $display("FAIL alt_order ack %0d owner got %b expected %b", i, ack_port_q[i], exp_p);
      end
      if (i > 0) begin
        n_checks++;
        if (ack_cyc_q[i] - ack_cyc_q[i-1] != S0+3) begin
          n_fail++;
          $display("FAIL alt_spacing ack %0d spacing got %0d expected %0d",
                   i, ack_cyc_q[i] - ack_cyc_q[i-1], S0+3);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit          found;
    logic [31:0] wd;
    wd = $urandom;
    found = 0;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h1000_0030; bus.d_wdata = wd;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (bus.sram_we) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL abort_setup sram_we got 0 expected 1 within 8 cycles");
    end
    reset = 1'b1;
    bus.d_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.sram_cs, bus.sram_oe, bus.sram_we, bus.if_ack, bus.d_ack, bus.if_rdata, bus.d_rdata} !== '0) begin
      n_fail++;
      $display("FAIL abort_reset cs/oe/we/acks=%b%b%b%b%b rd=%h/%h expected all 0",
               bus.sram_cs, bus.sram_oe, bus.sram_we, bus.if_ack, bus.d_ack, bus.if_rdata, bus.d_rdata);
    end
    reset = 1'b0;
    exp_if_rd = '0;
    exp_d_rd = '0;
    model_last = OWN_FETCH;
    repeat (6) begin
      @(negedge clk);
      n_checks++;
      if ({bus.sram_cs, bus.d_ack, bus.if_ack} !== 3'b000) begin
        n_fail++;
        $display("FAIL abort_quiet cs/d_ack/if_ack got %b%b%b expected 000", bus.sram_cs, bus.d_ack, bus.if_ack);
      end
    end
    txn(OWN_DATA, 1'b1, 32'h1000_0030, wd, 1'b1);
    txn(OWN_DATA, 1'b0, 32'h1000_0030, 32'h0, 1'b1);
  endtask

  task automatic test_random();
    fork
      begin
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        repeat (25) begin
          w = 1'($urandom_range(0, 1));
          a = 32'h1000_0000 + 32'($urandom_range(0, 3)) * 4;
          d = $urandom;
          txn(OWN_DATA, w, a, d, 1'b0);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      begin
        logic [31:0] a;
        repeat (25) begin
          a = 32'h0040_0000 + 32'($urandom_range(0, 31)) * 4;
          txn(OWN_FETCH, 1'b0, a, 32'h0, 1'b0);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
    join
  endtask

  task automatic test_strobe1_back_to_back();
    bit          got;
    int          k;
    int          c0;
    logic [31:0] a;
    c0 = 0;
    for (int t = 0; t < 2; t++) begin
      a = (t == 0) ? 32'h0040_0020 : 32'h0040_0024;
      bus1.if_req = 1'b1;
      bus1.if_addr = a;
      got = 0;
      k = 0;
      while (!got && k < 20) begin
        @(negedge clk);
        k++;
        if (bus1.if_ack) begin
          got = 1;
          bus1.if_req = 1'b0;
          n_checks++;
          if (bus1.if_rdata !== init_word(a) || bus1.d_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL s1_data fetch %0d if_rdata got %h expected %h, d_ack %b",
                     t, bus1.if_rdata, init_word(a), bus1.d_ack);
          end
          n_checks++;
          if (t == 0 && k != 2+S1) begin
            n_fail++;
            $display("FAIL s1_latency ack after %0d cycles expected %0d", k, 2+S1);
          end else if (t == 1 && cyc - c0 != S1+3) begin
            n_fail++;
            $display("FAIL s1_spacing ack spacing got %0d expected %0d", cyc - c0, S1+3);
          end
          c0 = cyc;
        end
      end
      if (!got) begin
        n_checks++;
        n_fail++;
        $display("FAIL s1_timeout fetch %0d no ack within 20 cycles", t);
        bus1.if_req = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    bus.if_req = 1'b0;  bus.if_addr = '0;  bus.d_req = 1'b0;  bus.d_we = 1'b0;
    bus.d_addr = '0;    bus.d_wdata = '0;
    bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
    bus1.d_addr = '0;   bus1.d_wdata = '0;
    test_reset();
    test_store_load();
    test_single_fetch();
    test_alternate();
    test_reset_mid();
    test_random();
    test_strobe1_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Two-port arbiter/sequencer that shares the single-port sram model between the instruction-fetch port (read-only) and the load/store data port.
- Grants one requester at a time, round-robin.
- Latches address/data, then drives cs/oe/we with a setup cycle and a programmable strobe length.
- Returns read data with a one-cycle ack.
- Sits between the CPU fetch/memory stages and the sram instance.

Parameters:
ADDR_W, 32, address width for both ports and sram_addr
DATA_W, 32, data width
STROBE_CYC, 2, cycles oe/we held asserted (legal 1..15)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch read request; held until if_ack
if_addr  in  ADDR_W  fetch address
if_ack  out  1  one-cycle completion pulse, fetch port
if_rdata  out  DATA_W  fetch read data, valid from if_ack until next if_ack
d_req  in  1  data request; held until d_ack
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_ack  out  1  one-cycle completion pulse, data port
d_rdata  out  DATA_W  load data, valid from d_ack until next load d_ack
sram_cs  out  1  chip select to sram
sram_oe  out  1  output enable to sram
sram_we  out  1  write enable to sram
sram_addr  out  ADDR_W  sram address
sram_din  out  DATA_W  sram write data
sram_dout  in  DATA_W  sram read data

Behaviour:
- Reset: state=IDLE; sram_cs/oe/we=0; sram_addr=0, sram_din=0; if_ack=d_ack=0; if_rdata=d_rdata=0; last_grant=FETCH, so data wins the first tie. Reset mid-transaction aborts: strobes drop on the next edge, no ack is issued, and the transaction is lost.
- FSM states: IDLE, SETUP, STROBE, DONE. All outputs are registered.
- IDLE:
  - If any req is high at the edge, select the winner, latch the owner, addr, we, and wdata (forced 0 for fetch), and go to SETUP.
  - Only one req high: that port wins.
  - Both high: the port not equal to last_grant wins.
  - last_grant is updated at grant.
- SETUP (1 cycle): sram_cs=1, sram_addr/din stable, oe=we=0. Then go to STROBE with cnt=STROBE_CYC-1.
- STROBE (STROBE_CYC cycles):
  - cs=1; oe=!we_l; we=we_l.
  - cnt decrements each cycle.
  - When cnt==0: for a read, capture sram_dout into the owner's rdata register on that edge; then go to DONE.
- DONE (1 cycle):
  - cs/oe/we=0.
  - The owner's ack=1 for exactly this cycle; the other ack stays 0.
  - Next state is IDLE.
- Latency: req sampled high at edge N in IDLE → SETUP in cycle N+1 → STROBE in cycles N+2..N+1+STROBE_CYC → ack in cycle N+2+STROBE_CYC. With the default (2), ack comes 4 cycles after the grant edge. Minimum spacing between grants is STROBE_CYC+3 cycles.
- Requester rules:
  - Hold req until ack, and drop it in the ack cycle.
  - req still high in the cycle after ack is treated as a new request.
  - Changes to addr/wdata after grant are ignored.
- Stores: d_ack is issued after the strobe; d_rdata is unchanged by stores.
- Starvation: a port with req held high is granted within one other transaction.
- sram_addr/sram_din hold their last values in IDLE/DONE; only the cs/oe/we strobes return to 0.
- Illegal case: the d_we=1 path is never taken for the fetch port, since the fetch port has no write.

Decomposition:
- Shared header sram_arb_defs.vh holds:
  - state encodings ST_IDLE=2'd0, ST_SETUP=2'd1, ST_STROBE=2'd2, ST_DONE=2'd3
  - owner encodings OWN_FETCH=1'b0, OWN_DATA=1'b1
  - counter width CNT_W=4
- One sub-module, rr_arb2: combinational two-requester round-robin picker with inputs req[1:0] and last, and one-hot grant output. Instantiated once in sram_arbiter.

Test Plan:
- Reset held 2 cycles with both reqs high → all strobes and acks stay 0, no grant. Release reset → data granted first.
- Single fetch read, if_addr=0x00400050, sram preloaded → cs rises at N+1, oe at N+2..N+3, if_ack at N+4 with if_rdata = the word at 0x00400050.
- Store, then load: d_we=1, d_addr=0x10000024, d_wdata=0x00000007 → sram_we high exactly 2 cycles, d_ack pulse. Then store 0x00000009 to the same address, then load 0x10000024 → d_rdata=0x00000009.
- Simultaneous if_req (0x0040002c) and d_req load (0x10000024) held continuously → grants alternate D,F,D,F. Each ack is exactly 1 cycle, and the other port's rdata is unchanged.
- Reset asserted during STROBE of a store → sram_we=0 next cycle, no d_ack, FSM returns to IDLE. A re-issued request completes normally.
- STROBE_CYC=1 build: back-to-back fetches to 0x00400020 / 0x00400024 → acks spaced exactly 4 cycles apart, correct data each time.
